debounce_enable: RTL and testbench

- Upstream conditioning stage for the board-level counter/blinker. Turns a raw, bouncy, asynchronous push-button or switch input into clean single-clock-domain control signals.
- Its en_o drives the counter's enable input directly.
- Pipeline: multi-flop synchronizer, then a debounce counter with a 4-state FSM, then registered level, edge-pulse and enable outputs.

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_enable_sync_bit.sv | 39 +++
 rtl/debounce_enable.sv | 110 +++++++++++
 tb/tb_debounce_enable.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the debounce_enable conditioning stage.
// Optional feature macro used by the top: DEBOUNCE_TOGGLE_EN.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HI,
        S_HIGH,
        S_WAIT_LO
    } db_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;

    // Saturating increment: the qualification counter never wraps past its terminal count.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
        return (value >= limit) ? limit : value + 32'd1;
    endfunction

endpackage

// File: rtl/debounce_enable_sync_bit.sv
// sync_bit: STAGES-deep flop chain that brings an asynchronous level into the clk_i domain.
// All stages clear asynchronously on rst_i.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_sync;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        r_sync[gi] <= 1'b0;
                    end else begin
                        r_sync[gi] <= d_i;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        r_sync[gi] <= 1'b0;
                    end else begin
                        r_sync[gi] <= r_sync[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_enable.sv
// debounce_enable: synchronizer + 4-state debounce FSM producing registered level/rise/fall/enable.
// DEBOUNCE_TOGGLE_EN: when defined, en_o toggles on each accepted press instead of following level_o.
module debounce_enable
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic en_o
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_s;
    logic [CNT_W-1:0] w_cnt_inc;

    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_en;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (btn_i),
        .q_o   (w_s)
    );

    assign w_cnt_inc = CNT_W'(sat_inc(32'(r_cnt), 32'(CNT_LAST)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (w_s) begin
                        r_state <= S_WAIT_HI;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT_HI: begin
                    // A drop back to 0 abandons the attempt; the next one starts from cnt=0.
                    if (!w_s) begin
                        r_state <= S_LOW;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_HIGH;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
`ifdef DEBOUNCE_TOGGLE_EN
                        r_en    <= ~r_en;
`else
                        r_en    <= 1'b1;
`endif
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_HIGH: begin
                    if (!w_s) begin
                        r_state <= S_WAIT_LO;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT_LO: begin
                    if (w_s) begin
                        r_state <= S_HIGH;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_LOW;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
`ifndef DEBOUNCE_TOGGLE_EN
                        r_en    <= 1'b0;
`endif
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign level_o = r_level;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;
    assign en_o    = r_en;

endmodule

// File: tb/tb_debounce_enable.sv
// Directed scoreboard bench for debounce_enable (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Builds with or without DEBOUNCE_TOGGLE_EN; en_o expectations follow the build.
module tb_debounce_enable;
    import debounce_pkg::*;

`ifdef DEBOUNCE_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    typedef struct {
        string tag;
        logic  lv;
        logic  ri;
        logic  fa;
        logic  en;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic level_o, rise_o, fall_o, en_o;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic en_m  = 1'b0;

    always #5 clk = ~clk;

    debounce_enable #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (btn),
        .level_o (level_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .en_o    (en_o)
    );

    task automatic cmp(input string tag, input string sig, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s %s got=%b exp=%b", tag, sig, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic lv, input logic ri, input logic fa, input logic en);
        cmp(tag, "level_o", level_o, lv);
        cmp(tag, "rise_o", rise_o, ri);
        cmp(tag, "fall_o", fall_o, fa);
        cmp(tag, "en_o", en_o, en);
        $display("t=%0t %s btn=%b lv=%b ri=%b fa=%b en=%b", $time, tag, btn, level_o, rise_o, fall_o, en_o);
    endtask

    task automatic check_state(input string tag, input db_state_t exp);
        total++;
        assert (dut.r_state === exp) else begin
            bad++;
            $error("FAIL %s state got=%0d exp=%0d", tag, dut.r_state, exp);
        end
    endtask

    task automatic expect_n(input string tag, input int n, input logic lv, input logic ri,
                            input logic fa, input logic en);
        exp_t e;
        e.tag = tag; e.lv = lv; e.ri = ri; e.fa = fa; e.en = en;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    task automatic run_edges(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL scoreboard_empty got=0 exp=1");
            end else begin
                e = q.pop_front();
                check_outs(e.tag, e.lv, e.ri, e.fa, e.en);
            end
        end
    endtask

    // Full press qualification with btn already at 1: six quiet edges, rise on the seventh.
    task automatic press_seq(input string tag);
        expect_n({tag, "_wait"}, 6, 1'b0, 1'b0, 1'b0, en_m);
        en_m = TOG ? ~en_m : 1'b1;
        expect_n({tag, "_rise"}, 1, 1'b1, 1'b1, 1'b0, en_m);
        expect_n({tag, "_hold"}, 3, 1'b1, 1'b0, 1'b0, en_m);
        run_edges(10);
    endtask

    task automatic release_seq(input string tag);
        btn = 1'b0;
        expect_n({tag, "_wait"}, 6, 1'b1, 1'b0, 1'b0, en_m);
        en_m = TOG ? en_m : 1'b0;
        expect_n({tag, "_fall"}, 1, 1'b0, 1'b0, 1'b1, en_m);
        expect_n({tag, "_hold"}, 3, 1'b0, 1'b0, 1'b0, en_m);
        run_edges(10);
    endtask

    initial begin
        logic [4:0] bounce_pat;
        rst = 1'b0;
        btn = 1'b0;
        #2 rst = 1'b1;
        #1 check_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("rst_async", S_LOW);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        expect_n("idle", 3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_edges(3);

        btn = 1'b1;
        press_seq("press1");
        release_seq("release1");

        btn = 1'b1;
        expect_n("glitch_hi", 3, 1'b0, 1'b0, 1'b0, en_m);
        run_edges(3);
        btn = 1'b0;
        expect_n("glitch_lo", 10, 1'b0, 1'b0, 1'b0, en_m);
        run_edges(10);
        check_state("glitch_end", S_LOW);

        bounce_pat = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            btn = bounce_pat[i];
            expect_n("bounce", 1, 1'b0, 1'b0, 1'b0, en_m);
            run_edges(1);
        end
        btn = 1'b1;
        press_seq("settle");
        release_seq("release2");

        btn = 1'b1;
        expect_n("midwait", 4, 1'b0, 1'b0, 1'b0, en_m);
        run_edges(4);
        check_state("midwait", S_WAIT_HI);
        #1 rst = 1'b1;
        en_m = 1'b0;
        #1 check_outs("rst_midwait", 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("rst_midwait", S_LOW);
        #1 rst = 1'b0;
        press_seq("after_rst");

        #1 rst = 1'b1;
        en_m = 1'b0;
        #1 check_outs("rst_high", 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("rst_high", S_LOW);
        #1 rst = 1'b0;
        press_seq("held_thru_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
